serial_parity_acc: RTL and testbench

//   Downstream consumer of the XOR primitive. Folds a serial bit stream into a

---
 rtl/serial_parity_acc.sv | 109 ++++++++++
 tb/tb_serial_parity_acc.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_parity_acc.sv
// serial_parity_acc
//   Folds a serial bit stream into a running XOR and emits one parity bit per
//   FRAME_LEN-bit frame over a valid/ready handshake. While a result is pending,
//   input is stalled (in_ready_o=0). in_ready_o returns the cycle after the
//   result is taken.
//
//   Build option: define ODD_PARITY_EN to emit odd parity, which is the
//   complement of the XOR. Left undefined, the block emits even parity, which
//   is the plain XOR. Handshake and timing are the same in both builds.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset
//   in_bit_i     serial data bit
//   in_valid_i   in_bit_i valid this cycle
//   in_ready_o   block accepts in_bit_i this cycle
//   par_out_o    parity of the completed frame (meaningful while par_valid_o)
//   par_valid_o  par_out_o valid, held until taken
//   par_ready_i  consumer takes par_out_o this cycle
//   bit_count_o  bits accepted in the current frame
module serial_parity_acc #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_bit_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             par_out_o,
  output logic             par_valid_o,
  input  logic             par_ready_i,
  output logic [CNT_W-1:0] bit_count_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e           state_q;
  logic             acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             par_valid_q;
  logic             par_out_q;

  logic             accept;
  logic             acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             last;
  logic             par_d;

  always_comb begin
    accept = in_valid_i & in_ready_q;
    acc_d  = acc_q ^ in_bit_i;
    cnt_d  = cnt_q + CNT_W'(1);
    last   = (cnt_d == CNT_W'(FRAME_LEN));
`ifdef ODD_PARITY_EN
    par_d  = ~acc_d;
`else
    par_d  = acc_d;
`endif
  end

  // The counter holds FRAME_LEN while DONE and is cleared on the handshake,
  // so it never wraps.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      par_valid_q <= 1'b0;
      par_out_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (last) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              par_valid_q <= 1'b1;
              par_out_q   <= par_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          // par_out_q is left at its last value after the handshake.
          if (par_ready_i) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            par_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign par_valid_o = par_valid_q;
  assign par_out_o   = par_out_q;
  assign bit_count_o = cnt_q;

endmodule

// File: tb/tb_serial_parity_acc.sv
// Directed bench for serial_parity_acc (FRAME_LEN=8, CNT_W=4).
// Expected parities are hand-computed even parities. They are complemented
// when the bench is built with ODD_PARITY_EN.
module tb_serial_parity_acc;

`ifdef ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, in_bit, in_valid, par_ready;
  logic       in_ready, par_out, par_valid;
  logic [3:0] bit_count;

  int nvec = 0;
  int nerr = 0;

  serial_parity_acc #(.FRAME_LEN(8), .CNT_W(4)) dut (
    .clk_i(clk), .reset_i(reset), .in_bit_i(in_bit), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .par_out_o(par_out), .par_valid_o(par_valid),
    .par_ready_i(par_ready), .bit_count_o(bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Outputs are sampled and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic pv, input logic po,
                         input logic ir, input logic [3:0] bc);
    chk({tag, ".par_valid"}, 32'(par_valid), 32'(pv));
    chk({tag, ".par_out"},   32'(par_out),   32'(po));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, ".bit_count"}, 32'(bit_count), 32'(bc));
  endtask

  // Send f[7] first, back-to-back. Checks bit_count after every accept.
  task automatic send_frame(input string tag, input logic [7:0] f);
    for (int i = 7; i >= 0; i--) begin
      in_valid = 1'b1;
      in_bit   = f[i];
      step();
      chk({tag, ".cnt"}, 32'(bit_count), 32'(8 - i));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; par_ready = 1'b0;
    #1;

    // 1: reset with random inputs
    for (int c = 0; c < 2; c++) begin
      in_bit    = 1'($urandom);
      in_valid  = 1'($urandom);
      par_ready = 1'($urandom);
      step();
      chk_out("rst", 1'b0, 1'b0, 1'b1, 4'd0);
    end
    reset = 1'b0; in_valid = 1'b0; par_ready = 1'b1;

    // 2: back-to-back frame, consumer ready
    send_frame("t2", 8'b1011_0010);
    chk_out("t2.done", 1'b1, 1'b0 ^ ODD, 1'b0, 4'd8);
    step();
    chk_out("t2.rel", 1'b0, 1'b0 ^ ODD, 1'b1, 4'd0);

    // 3: backpressure for 3 cycles, input toggling and ignored
    par_ready = 1'b0;
    send_frame("t3", 8'b1111_1000);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk_out("t3.hold", 1'b1, 1'b1 ^ ODD, 1'b0, 4'd8);
      in_bit = ~in_bit;
      if (c == 2) par_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk_out("t3.rel", 1'b0, 1'b1 ^ ODD, 1'b1, 4'd0);
    // next frame starts clean: all zeros
    send_frame("t3z", 8'b0000_0000);
    chk_out("t3z.done", 1'b1, ODD, 1'b0, 4'd8);
    step();
    chk_out("t3z.rel", 1'b0, ODD, 1'b1, 4'd0);

    // 4: gaps on alternate cycles
    begin
      logic [7:0] f;
      f = 8'b1011_0010;
      for (int i = 7; i >= 0; i--) begin
        in_valid = 1'b0;
        in_bit   = ~f[i];
        step();
        chk("t4.gap", 32'(bit_count), 32'(7 - i));
        in_valid = 1'b1;
        in_bit   = f[i];
        step();
        chk("t4.acc", 32'(bit_count), 32'(8 - i));
      end
      in_valid = 1'b0;
      chk_out("t4.done", 1'b1, 1'b0 ^ ODD, 1'b0, 4'd8);
      step();
      chk_out("t4.rel", 1'b0, 1'b0 ^ ODD, 1'b1, 4'd0);
    end

    // 5: reset mid-frame after five ones, then a fresh frame
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      step();
    end
    chk("t5.pre", 32'(bit_count), 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk_out("t5.rst", 1'b0, 1'b0, 1'b1, 4'd0);
    send_frame("t5", 8'b0000_0001);
    chk_out("t5.done", 1'b1, 1'b1 ^ ODD, 1'b0, 4'd8);
    step();

    // reset while a result is pending drops it
    par_ready = 1'b0;
    send_frame("t6", 8'b1000_0000);
    chk_out("t6.done", 1'b1, 1'b1 ^ ODD, 1'b0, 4'd8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("t6.rst", 1'b0, 1'b0, 1'b1, 4'd0);
    step();
    chk("t6.idle", 32'(par_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
